// File: rtl/seg_scan_capture.sv
// Multiplexed seven-segment scanner: walks a one-hot digit select, samples the
// shared bus after a settle delay and publishes a decoded hex frame atomically.
// Define SEG_AUTO_SCAN_EN for continuous back-to-back frame scanning.
module seg_scan_capture #(
   parameter int DIGITS = 4,
   parameter int SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            seg,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   hex,
   output logic [DIGITS-1:0]     dp,
   output logic                  valid,
   output logic                  busy,
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [7:0]    CNT_END  = 8'(SETTLE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

   state_t                r_state;
   logic [IW-1:0]         r_idx;
   logic [7:0]            r_cnt;
   logic [DIGITS-1:0]     r_dig_sel;
   logic [4*DIGITS-1:0]   r_sh_hex;
   logic [DIGITS-1:0]     r_sh_dp;
   logic                  r_sh_err;
   logic [4*DIGITS-1:0]   r_hex;
   logic [DIGITS-1:0]     r_dp;
   logic                  r_err;
   logic                  r_valid;

   logic [3:0]            w_nib;
   logic                  w_bad;

   // Single shared decoder; unknown patterns map to 0 and flag the frame.
   always_comb begin
      w_nib = 4'h0;
      w_bad = 1'b0;
      case (seg[6:0])
         7'h3f: w_nib = 4'h0;
         7'h06: w_nib = 4'h1;
         7'h5b: w_nib = 4'h2;
         7'h4f: w_nib = 4'h3;
         7'h66: w_nib = 4'h4;
         7'h6d: w_nib = 4'h5;
         7'h7d: w_nib = 4'h6;
         7'h07: w_nib = 4'h7;
         7'h7f: w_nib = 4'h8;
         7'h6f: w_nib = 4'h9;
         7'h77: w_nib = 4'hA;
         7'h7c: w_nib = 4'hB;
         7'h39: w_nib = 4'hC;
         7'h5e: w_nib = 4'hD;
         7'h79: w_nib = 4'hE;
         7'h71: w_nib = 4'hF;
         default: w_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_dig_sel <= '0;
         r_sh_hex  <= '0;
         r_sh_dp   <= '0;
         r_sh_err  <= 1'b0;
         r_hex     <= '0;
         r_dp      <= '0;
         r_err     <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_SETTLE;
                  r_idx     <= '0;
                  r_cnt     <= '0;
                  r_dig_sel <= DIGITS'(1);
               end
            end
            ST_SETTLE: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == CNT_END) r_state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               r_sh_hex[4*r_idx +: 4] <= w_nib;
               r_sh_dp[r_idx]         <= seg[7];
               r_sh_err               <= r_sh_err | w_bad;
               if (r_idx == LAST_IDX) begin
                  r_state   <= ST_DONE;
                  r_dig_sel <= '0;
               end else begin
                  r_state   <= ST_SETTLE;
                  r_idx     <= r_idx + 1'b1;
                  r_cnt     <= '0;
                  r_dig_sel <= r_dig_sel << 1;
               end
            end
            ST_DONE: begin
               r_hex    <= r_sh_hex;
               r_dp     <= r_sh_dp;
               r_err    <= r_sh_err;
               r_valid  <= 1'b1;
               r_sh_err <= 1'b0;
`ifdef SEG_AUTO_SCAN_EN
               r_state   <= ST_SETTLE;
               r_idx     <= '0;
               r_cnt     <= '0;
               r_dig_sel <= DIGITS'(1);
`else
               r_state   <= ST_IDLE;
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dig_sel = r_dig_sel;
   assign hex     = r_hex;
   assign dp      = r_dp;
   assign err     = r_err;
   assign valid   = r_valid;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: emulates the display bus and checks
// select walk, timing and decoded frames against table and model expectations.
module tb_seg_scan_capture;
   localparam int D   = 4;
   localparam int S   = 2;
   localparam int LAT = D * (S + 1) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [7:0]     seg;
   logic [D-1:0]   dig_sel;
   logic [4*D-1:0] hex;
   logic [D-1:0]   dp;
   logic           valid, busy, err;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] pat [D];
   logic [6:0] codes [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                              7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

   typedef struct {
      logic [D-1:0][7:0] p;
      logic [4*D-1:0]    h;
      logic [D-1:0]      d;
      logic              e;
   } vec_t;
   vec_t tbl [6];

   seg_scan_capture #(.DIGITS(D), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .seg(seg), .dig_sel(dig_sel),
      .hex(hex), .dp(dp), .valid(valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Display side: the selected digit drives the shared bus.
   always_comb begin
      seg = 8'h00;
      for (int i = 0; i < D; i++) if (dig_sel[i]) seg = pat[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void model(output logic [4*D-1:0] h, output logic [D-1:0] d, output logic e);
      h = '0; d = '0; e = 1'b0;
      for (int i = 0; i < D; i++) begin
         logic found = 1'b0;
         for (int k = 0; k < 16; k++)
            if (pat[i][6:0] == codes[k]) begin h[4*i +: 4] = 4'(k); found = 1'b1; end
         if (!found) e = 1'b1;
         d[i] = pat[i][7];
      end
   endfunction

   // One start pulse; checks every cycle up to and a few cycles past the valid pulse.
   task automatic frame(input logic [4*D-1:0] eh, input logic [D-1:0] ed, input logic ee,
                        input int ign_at);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < LAT + 4; j++) begin
         @(negedge clk);
         start = (j == ign_at);
         chk("dig_sel", 32'(dig_sel), (j < D*(S+1)) ? (32'd1 << (j/(S+1))) : 32'd0);
         chk("valid", 32'(valid), 32'(j == LAT));
         chk("busy", 32'(busy), 32'(j < LAT));
         if (j == LAT) begin
            chk("hex", 32'(hex), 32'(eh));
            chk("dp", 32'(dp), 32'(ed));
            chk("err", 32'(err), 32'(ee));
         end
      end
   endtask

   task automatic load(input logic [D-1:0][7:0] p);
      for (int i = 0; i < D; i++) pat[i] = p[i];
   endtask

   initial begin
      logic [4*D-1:0] mh; logic [D-1:0] md; logic me;
      for (int i = 0; i < D; i++) pat[i] = 8'h00;
      tbl[0] = '{p: {8'h66, 8'h4f, 8'h5b, 8'h06}, h: 16'h4321, d: 4'b0000, e: 1'b0};
      tbl[1] = '{p: {8'h66, 8'h00, 8'hff, 8'h06}, h: 16'h4081, d: 4'b0010, e: 1'b1};
      tbl[2] = '{p: {8'h3f, 8'h3f, 8'h3f, 8'h3f}, h: 16'h0000, d: 4'b0000, e: 1'b0};
      tbl[3] = '{p: {8'h71, 8'h79, 8'h5e, 8'h39}, h: 16'hFEDC, d: 4'b0000, e: 1'b0};
      tbl[4] = '{p: {8'hf7, 8'h7c, 8'hef, 8'h7f}, h: 16'hAB98, d: 4'b1010, e: 1'b0};
      tbl[5] = '{p: {8'h07, 8'h7d, 8'h6d, 8'h4f}, h: 16'h7653, d: 4'b0000, e: 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle_dig_sel", 32'(dig_sel), 0);
         chk("idle_busy", 32'(busy), 0);
         chk("idle_valid", 32'(valid), 0);
         chk("idle_hex", 32'(hex), 0);
         chk("idle_err", 32'(err), 0);
      end

`ifdef SEG_AUTO_SCAN_EN
      load(tbl[0].p);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 3*LAT + 2; j++) begin
         @(negedge clk);
         start = 1'b0;
         chk("auto_valid", 32'(valid), 32'(j > 0 && j % LAT == 0));
         chk("auto_busy", 32'(busy), 1);
         if (j == LAT) chk("auto_hex1", 32'(hex), 32'h4321);
         if (j == 2*LAT) chk("auto_hex2", 32'(hex), 32'h432F);
         if (j == 3*LAT) chk("auto_hex3", 32'(hex), 32'h4321);
         if (j == LAT) pat[0] = 8'h71;
         if (j == 2*LAT) pat[0] = 8'h06;
      end
`else
      foreach (tbl[t]) begin
         load(tbl[t].p);
         model(mh, md, me);
         chk("model_vs_table", 32'(mh), 32'(tbl[t].h));
         frame(tbl[t].h, tbl[t].d, tbl[t].e, -1);
      end

      // second start mid-frame must be ignored
      load(tbl[0].p);
      frame(16'h4321, 4'b0000, 1'b0, 4);

      // reset during digit 2 settle discards everything
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      for (int j = 0; j <= 2*(S+1); j++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("rst_dig_sel", 32'(dig_sel), 0);
      chk("rst_hex", 32'(hex), 0);
      chk("rst_dp", 32'(dp), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(valid), 0);
      @(negedge clk) rst = 1'b0;
      load(tbl[3].p);
      frame(tbl[3].h, tbl[3].d, tbl[3].e, -1);

      // random frames: mostly legal codes, occasional garbage, random dp
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < D; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 5) == 0) b = 8'($urandom);
            else b = {1'b0, codes[$urandom_range(0, 15)]};
            b[7] = 1'($urandom);
            pat[i] = b;
         end
         model(mh, md, me);
         frame(mh, md, me, (r % 3 == 0) ? $urandom_range(0, LAT - 3) : -1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Scan controller for a multiplexed 8-bit seven-segment bus (bit 7 = dp, bits 6:0 = segments g..a, active-high).
- Drives a one-hot digit select, waits a settle time, samples the shared bus and decodes each digit to a hex nibble with one shared decoder.
- Publishes a full DIGITS-wide hex word atomically with a one-cycle valid pulse.
- Sits between the display-side segment bus and downstream logic that needs numeric values.

Parameters:
- DIGITS, 4: number of digit positions scanned; legal range 1..8.
- SETTLE, 2: cycles dig_sel is held before sampling; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to scan one frame; sampled only in IDLE.
- seg  input  8  shared segment bus for the selected digit; seg[7]=dp.
- dig_sel  output  DIGITS  one-hot select of the digit being sampled; all zero when not scanning.
- hex  output  4*DIGITS  decoded frame; digit i in hex[4i+3:4i].
- dp  output  DIGITS  captured dp bit per digit.
- valid  output  1  one-cycle pulse when hex/dp/err update.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- err  output  1  frame flag: at least one digit pattern was not in the decode table.

Behaviour:
- Reset: state=IDLE, idx=0, settle counter=0. dig_sel, hex, dp, valid, busy and err all reset to 0. Reset mid-frame aborts the scan immediately, and partial shadow data is discarded.
- Decode of seg[6:0]: 3f->0, 06->1, 5b->2, 4f->3, 66->4, 6d->5, 7d->6, 07->7, 7f->8, 6f->9, 77->A, 7c->b, 39->C, 5e->d, 79->E, 71->F. Any other pattern decodes to 0 and sets the frame error bit. seg[7] is captured unchanged as dp.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE + start=1 -> SETTLE with idx=0 and counter=0. dig_sel is registered and equals 1<<idx throughout SETTLE and SAMPLE.
- SETTLE: counter increments each cycle. After exactly SETTLE cycles in this state -> SAMPLE.
- SAMPLE (one cycle): seg is sampled at the closing edge; the decoded nibble and dp go to shadow[idx]; the error bit is ORed into shadow_err.
  - If idx==DIGITS-1 -> DONE.
  - Otherwise idx+1 -> SETTLE with counter cleared.
- DONE (one cycle): shadow values are copied to hex/dp/err at the closing edge. valid=1 during the following cycle only. dig_sel=0. shadow_err is cleared. Then -> IDLE.
- Latency: start asserted at edge N gives valid high in the cycle after edge N + DIGITS*(SETTLE+1) + 1.
- start while not in IDLE is ignored, with no queuing.
- hex/dp/err hold their last published frame until the next DONE. A frame is never published partially.
- busy = (state != IDLE).

Optional Feature:
- Macro: SEG_AUTO_SCAN_EN.
- Defined: DONE goes directly to SETTLE with idx=0, counter=0 and shadow_err cleared, so scanning is continuous. start is ignored, busy stays 1, and valid pulses once per frame every DIGITS*(SETTLE+1)+1 cycles.
- Undefined: single-frame behaviour as above, with DONE -> IDLE.

Test Plan:
- Reset and idle: assert rst mid-idle, release, hold start=0 for 20 cycles -> dig_sel=0, busy=0, valid never pulses, hex=0, err=0.
- Basic frame (DIGITS=4, SETTLE=2): bench returns 0x06, 0x5b, 0x4f, 0x66 on digits 0..3 while the matching dig_sel bit is set; pulse start -> dig_sel walks 0001, 0010, 0100, 1000 for 3 cycles each; valid 13 cycles after start; hex=16'h4321, dp=0, err=0.
- dp and invalid pattern: digit1 returns 0x80|0x7f, digit2 returns 0x00 -> hex[7:4]=8, dp=4'b0010, hex[11:8]=0, err=1. The next clean frame gives err=0.
- Ignored start: pulse start again at cycle 5 of a frame -> exactly one valid pulse, with the same timing as a single start.
- Reset mid-frame: assert rst during digit 2 SETTLE after a prior valid frame hex=16'h4321 -> all outputs 0 immediately; a new start produces a full fresh frame.
- With SEG_AUTO_SCAN_EN and one start -> valid pulses every 13 cycles. Change digit0 to 0x71 between frames -> hex[3:0]=F on the next pulse only.
